// File: rtl/jt51_exp2lin.sv
// jt51_exp2lin
//   Converts a log-domain operator level into a signed linear sample using the
//   32x45 exponential ROM. The level is split into a shift amount, a ROM
//   address and a 3-bit fine index. The ROM word holds a 10-bit base mantissa
//   and seven 5-bit deltas, one for each non-zero fine step. The module
//   subtracts the selected delta, restores the implicit leading one, scales the
//   result to OW-1 bits and shifts it right. It then applies the sign.
//
//   Optional build macro: JT51_EXP2LIN_ROUND_EN
//     undefined : the right shift truncates
//     defined   : the right shift rounds half-up, saturated to the magnitude max
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset (dominates cen)
//   cen        clock enable; every register holds while cen=0
//   in_valid   a log value is present on this cen tick
//   in_log     [12:8] shift, [7:3] ROM address, [2:0] fine index
//   in_sign    1 = negative result
//   rom_addr   registered address to the exponential ROM
//   rom_data   ROM word, valid one cen tick after rom_addr
//   out_valid  out_lin carries a new sample
//   out_lin    signed (two's complement) linear sample, OW bits
//
// Handshake: in_valid is qualified only by cen. There is no backpressure. Each
// accepted input produces exactly one out_valid pulse three cen ticks later,
// and samples leave in the order they arrived. On cen ticks with
// out_valid=0, out_lin keeps the last emitted sample.
//
// Pipeline
//   stage 1 : capture input, present rom_addr
//   stage 2 : ROM registers its word; shift/fine/sign/valid ride alongside
//   stage 3 : interpolate, scale, shift, sign, register the output
//
// OW must lie in 12..16. The magnitude path is OW-1 bits wide, so
// {1, mant} << (OW-12) fills it exactly.

module jt51_exp2lin #(
   parameter int OW = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          in_valid,
   input  logic [12:0]   in_log,
   input  logic          in_sign,
   output logic [4:0]    rom_addr,
   input  logic [44:0]   rom_data,
   output logic          out_valid,
   output logic [OW-1:0] out_lin
);

   localparam int MW = OW - 1;   // magnitude width

   // stage 1 registers
   logic       s1_valid;
   logic [4:0] s1_shift;
   logic [2:0] s1_fine;
   logic       s1_sign;

   // stage 2 registers (aligned with rom_data)
   logic       s2_valid;
   logic [4:0] s2_shift;
   logic [2:0] s2_fine;
   logic       s2_sign;

   // stage 3 combinational datapath
   logic [9:0]    base;
   logic [4:0]    delta;
   logic [9:0]    mant;
   logic [MW-1:0] x;
   logic [MW-1:0] mag;
   logic [OW-1:0] lin;

`ifdef JT51_EXP2LIN_ROUND_EN
   logic [MW:0]   sum;
   logic [MW:0]   shifted;
`endif

   always_comb begin
      base  = rom_data[44:35];
      delta = 5'd0;
      case (s2_fine)
         3'd1:    delta = rom_data[34:30];
         3'd2:    delta = rom_data[29:25];
         3'd3:    delta = rom_data[24:20];
         3'd4:    delta = rom_data[19:15];
         3'd5:    delta = rom_data[14:10];
         3'd6:    delta = rom_data[9:5];
         3'd7:    delta = rom_data[4:0];
         default: delta = 5'd0;
      endcase

      // Clamp instead of wrapping when the delta exceeds the base.
      if ({5'd0, delta} > base) begin
         mant = 10'd0;
      end else begin
         mant = base - {5'd0, delta};
      end

      // Restore the implicit leading one and left-align to the magnitude width.
      x = MW'({1'b1, mant}) << (OW - 12);

`ifdef JT51_EXP2LIN_ROUND_EN
      sum     = '0;
      shifted = '0;
      if (s2_shift >= 5'(MW)) begin
         mag = '0;
      end else if (s2_shift == 5'd0) begin
         mag = x;
      end else begin
         // Half-up: add half an LSB of the post-shift result before shifting.
         // One extra bit of headroom holds the carry out of the add.
         sum     = {1'b0, x} + ((MW+1)'(1) << 5'(s2_shift - 5'd1));
         shifted = sum >> s2_shift;
         if (shifted > {1'b0, {MW{1'b1}}}) begin
            mag = '1;
         end else begin
            mag = shifted[MW-1:0];
         end
      end
`else
      if (s2_shift >= 5'(MW)) begin
         mag = '0;
      end else begin
         mag = x >> s2_shift;
      end
`endif

      // Negating a zero magnitude gives zero, so there is no negative-zero case.
      lin = {1'b0, mag};
      if (s2_sign) begin
         lin = -lin;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_shift  <= 5'd0;
         s1_fine   <= 3'd0;
         s1_sign   <= 1'b0;
         rom_addr  <= 5'd0;
         s2_valid  <= 1'b0;
         s2_shift  <= 5'd0;
         s2_fine   <= 3'd0;
         s2_sign   <= 1'b0;
         out_valid <= 1'b0;
         out_lin   <= '0;
      end else if (cen) begin
         s1_valid  <= in_valid;
         s1_shift  <= in_log[12:8];
         s1_fine   <= in_log[2:0];
         s1_sign   <= in_sign;
         rom_addr  <= in_log[7:3];

         s2_valid  <= s1_valid;
         s2_shift  <= s1_shift;
         s2_fine   <= s1_fine;
         s2_sign   <= s1_sign;

         out_valid <= s2_valid;
         if (s2_valid) begin
            out_lin <= lin;
         end
      end
   end

endmodule

// File: tb/tb_jt51_exp2lin.sv
// Bench for jt51_exp2lin: a registered ROM model, a stimulus driver, and a
// scoreboard monitor that pops expected samples whenever out_valid appears.
module tb_jt51_exp2lin;
  localparam int OW = 14;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          in_valid = 1'b0;
  logic [12:0]   in_log = '0;
  logic          in_sign = 1'b0;
  logic [4:0]    rom_addr;
  logic [44:0]   rom_data = '0;
  logic          out_valid;
  logic [OW-1:0] out_lin;

  jt51_exp2lin #(.OW(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .in_valid  (in_valid),
    .in_log    (in_log),
    .in_sign   (in_sign),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_lin   (out_lin)
  );

  // ROM: registered on the same clk/cen
  logic [44:0] rom_mem [32];
  always @(posedge clk) if (cen) rom_data <= rom_mem[rom_addr];

  // scoreboard state
  int            n_checks = 0;
  int            n_pass = 0;
  logic [OW-1:0] exp_q [$];
  int            due_q [$];
  int            tick_cnt = 0;
  logic          cen_q = 1'b0;
  logic [OW-1:0] last_exp = '0;
  bit            have_last = 0;
  logic [OW-1:0] mon_e;
  int            mon_d;

  always @(posedge clk) begin
    cen_q <= cen;
    if (cen && rst_n) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, expv, expv, $time);
  endtask

  // reference model: plain arithmetic on the ROM word
  function automatic logic [OW-1:0] model(input logic [12:0] lg, input logic s);
    int sh, a, f, base, d, mant, x, mag;
    logic [44:0] w;
    sh = int'(lg[12:8]);
    a = int'(lg[7:3]);
    f = int'(lg[2:0]);
    w = rom_mem[a];
    base = int'(w[44:35]);
    d = (f == 0) ? 0 : int'((w >> (30 - 5 * (f - 1))) & 45'd31);
    mant = (d > base) ? 0 : base - d;
    x = (1024 + mant) * (2 ** (OW - 12));
    if (sh >= OW - 1) mag = 0;
`ifdef JT51_EXP2LIN_ROUND_EN
    else if (sh == 0) mag = x;
    else begin
      mag = (x + (2 ** (sh - 1))) / (2 ** sh);
      if (mag > 2 ** (OW - 1) - 1) mag = 2 ** (OW - 1) - 1;
    end
`else
    else mag = x / (2 ** sh);
`endif
    return s ? OW'(-mag) : OW'(mag);
  endfunction

  // driver tasks: inputs change 1 time unit after the falling edge
  task automatic drive_exp(input logic v, input logic [12:0] lg, input logic s, input logic c,
                           input logic [OW-1:0] e);
    @(negedge clk);
    #1;
    in_valid = v; in_log = lg; in_sign = s; cen = c;
    if (v && c && rst_n) begin
      exp_q.push_back(e);
      due_q.push_back(tick_cnt + 3);
    end
  endtask

  task automatic drive(input logic v, input logic [12:0] lg, input logic s, input logic c);
    drive_exp(v, lg, s, c, model(lg, s));
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && have_last) begin
      if (cen_q) begin
        if (out_valid) begin
          if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
          else begin
            mon_e = exp_q.pop_front();
            mon_d = due_q.pop_front();
            check("out_lin", 32'(out_lin), 32'(mon_e));
            check("latency_tick", 32'(tick_cnt), 32'(mon_d));
            last_exp = mon_e;
          end
        end else begin
          check("idle_hold", 32'(out_lin), 32'(last_exp));
        end
      end else begin
        check("cen0_hold", 32'(out_lin), 32'(last_exp));
      end
    end
  end

  initial begin
    for (int a = 0; a < 32; a++) rom_mem[a] = {13'($urandom), 32'($urandom)};
    rom_mem[0][44:35]  = 10'd1002;
    rom_mem[31][44:35] = 10'd372;
    rom_mem[1][44:35]  = 10'd512;
    rom_mem[1][24:20]  = 5'd20;
    rom_mem[2][44:35]  = 10'd10;
    rom_mem[2][24:20]  = 5'd31;

    // reset with cen=0 must still clear everything
    rst_n = 1'b0; cen = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_lin", 32'(out_lin), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    #1;
    rst_n = 1'b1;
    last_exp = '0;
    have_last = 1;

    // directed points
    drive_exp(1, 13'h000, 0, 1, OW'(8104));
    drive_exp(1, 13'h000, 1, 1, OW'(-8104));
`ifdef JT51_EXP2LIN_ROUND_EN
    drive_exp(1, 13'h5F8, 0, 1, OW'(175));
`else
    drive_exp(1, 13'h5F8, 0, 1, OW'(174));
`endif
    drive_exp(1, {5'd0, 5'd1, 3'd3}, 0, 1, OW'(6064));
    drive_exp(1, {5'd0, 5'd2, 3'd3}, 0, 1, OW'(4096));
    drive_exp(1, {5'd13, 5'd4, 3'd2}, 0, 1, OW'(0));
    drive_exp(1, {5'd13, 5'd0, 3'd0}, 1, 1, OW'(0));
    drive_exp(1, {5'd31, 5'd9, 3'd5}, 0, 1, OW'(0));
    drive_exp(1, {5'd31, 5'd0, 3'd0}, 1, 1, OW'(0));

    // cen toggling with in_valid every tick
    drive(1, 13'h023, 0, 1);
    drive(1, 13'h1A4, 1, 0);
    drive(1, 13'h0F1, 0, 0);
    drive(1, 13'h10A, 1, 1);
    drive(1, 13'h0C7, 0, 1);
    repeat (5) drive(0, '0, 0, 1);

    // reset with three samples in flight
    drive(1, 13'h0A9, 0, 1);
    drive(1, 13'h1F3, 1, 1);
    drive(1, 13'h04E, 0, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b0; cen = 1'b1;
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_lin", 32'(out_lin), 32'd0);
    #1;
    rst_n = 1'b1;
    last_exp = '0;
    repeat (5) drive(0, '0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 4) != 0), 13'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end

    // drain, bounded
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) drive(0, '0, 0, 1);
    drive(0, '0, 0, 1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
